// File: rtl/mm_ctrl.sv
// Memory-stage load/store controller: one access at a time, registered SRAM handshake, load align/extend.
// Min latency start->mm_done is 3 cycles; holds the EX/MM register via mm_stall until the result is taken.
`ifndef ACCESS_SZ_BYTE
`define ACCESS_SZ_BYTE 3'b000
`endif
`ifndef ACCESS_SZ_HALF
`define ACCESS_SZ_HALF 3'b001
`endif
`ifndef ACCESS_SZ_WORD
`define ACCESS_SZ_WORD 3'b010
`endif

module mm_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mm_re,
  input  logic        mm_we,
  input  logic [31:0] mm_addr,
  input  logic [31:0] mm_wdata,
  input  logic [2:0]  mm_access_sz,
  input  logic        mm_sign_ext,
  input  logic        ex_ale,
  input  logic        mm_cancel,
  input  logic        out_ready,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic [31:0] mm_rdata,
  output logic        mm_done,
  output logic        mm_stall
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        start;
  logic        cancel_pending;
  logic        sign_q;
  logic        capture;
  logic [1:0]  size_nxt;
  logic [3:0]  wstrb_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] load_sh;
  logic [31:0] load_val;

  assign start   = in_valid & (mm_re | mm_we) & ~ex_ale & ~mm_cancel;
  assign capture = (state == S_WAIT) & data_sram_data_ok & ~mm_cancel;

  // Bus-side formatting of the incoming request; unknown size codes behave as word.
  always_comb begin
    size_nxt  = 2'd2;
    wstrb_nxt = 4'b1111;
    wdata_nxt = mm_wdata;
    case (mm_access_sz)
      `ACCESS_SZ_BYTE: begin
        size_nxt  = 2'd0;
        wstrb_nxt = 4'b0001 << mm_addr[1:0];
        wdata_nxt = {4{mm_wdata[7:0]}};
      end
      `ACCESS_SZ_HALF: begin
        size_nxt  = 2'd1;
        wstrb_nxt = 4'b0011 << {mm_addr[1], 1'b0};
        wdata_nxt = {2{mm_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!mm_we) begin
      wstrb_nxt = 4'b0000;
    end
  end

  // Load alignment uses the latched low address bits, not the live EX/MM inputs.
  assign load_sh = data_sram_rdata >> {data_sram_addr[1:0], 3'b000};

  always_comb begin
    case (data_sram_size)
      2'd0:    load_val = {{24{sign_q & load_sh[7]}}, load_sh[7:0]};
      2'd1:    load_val = {{16{sign_q & load_sh[15]}}, load_sh[15:0]};
      default: load_val = data_sram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mm_done   = 1'b0;
    mm_stall  = 1'b0;
    case (state)
      S_IDLE: begin
        mm_stall = start;
        if (start) state_nxt = S_REQ;
      end
      S_REQ: begin
        mm_stall = 1'b1;
        if (data_sram_addr_ok) begin
          state_nxt = (cancel_pending | mm_cancel) ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        mm_stall = 1'b1;
        if (data_sram_data_ok) begin
          state_nxt = mm_cancel ? S_IDLE : S_DONE;
        end else if (mm_cancel) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DONE: begin
        mm_done  = 1'b1;
        mm_stall = ~out_ready;
        if (out_ready | mm_cancel) state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        mm_stall = 1'b1;
        if (data_sram_data_ok) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request fields are captured once at start so they stay frozen for the whole REQ phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_sram_req   <= 1'b0;
      data_sram_wr    <= 1'b0;
      data_sram_size  <= 2'd0;
      data_sram_wstrb <= 4'd0;
      data_sram_addr  <= 32'd0;
      data_sram_wdata <= 32'd0;
      sign_q          <= 1'b0;
      cancel_pending  <= 1'b0;
      mm_rdata        <= 32'd0;
    end else begin
      data_sram_req <= (state_nxt == S_REQ);
      if ((state == S_IDLE) && start) begin
        data_sram_wr    <= mm_we;
        data_sram_size  <= size_nxt;
        data_sram_wstrb <= wstrb_nxt;
        data_sram_addr  <= mm_addr;
        data_sram_wdata <= wdata_nxt;
        sign_q          <= mm_sign_ext;
      end
      if (state == S_REQ) begin
        cancel_pending <= (state_nxt == S_REQ) & (cancel_pending | mm_cancel);
      end else begin
        cancel_pending <= 1'b0;
      end
      if (capture) begin
        mm_rdata <= data_sram_wr ? 32'd0 : load_val;
      end
    end
  end

endmodule
